// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues credit-limited word fetches,
// buffers returned words in a small FIFO and flushes everything on a redirect.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   aq_pc     [DEPTH];

    logic          credit;
    logic          issue;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   in_use;
    logic [CW-1:0] out_nxt;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    always_comb begin
        in_use  = {1'b0, outstanding} + {1'b0, fifo_count};
        credit  = in_use < DEPTH_SUM;
        issue   = (state == RUN) && credit && !redirect_valid;
        // A response with nothing outstanding is a leftover from before reset.
        accept  = imem_rvalid && (outstanding != '0);
        drop    = accept && (redirect_valid || (drop_cnt != '0));
        push    = accept && !drop;
        pop     = instr_valid && instr_ready && !redirect_valid;
        out_nxt = outstanding + CW'(issue) - CW'(accept);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (fetch_en) state <= RUN;
                RUN:     if (!fetch_en) state <= DRAIN;
                DRAIN: begin
                    if (fetch_en)             state <= RUN;
                    else if (out_nxt == '0)   state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                // No issue this cycle, so out_nxt is exactly the in-flight count to discard.
                pc         <= {redirect_pc[31:2], 2'b00};
                drop_cnt   <= out_nxt;
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                aq_wr      <= '0;
                aq_rd      <= '0;
            end else begin
                if (issue) begin
                    pc    <= pc + 32'd4;
                    aq_wr <= aq_wr + 1'b1;
                end
                if (drop) drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    fifo_wr <= fifo_wr + 1'b1;
                    aq_rd   <= aq_rd + 1'b1;
                end
                if (pop) fifo_rd <= fifo_rd + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        if (issue) aq_pc[aq_wr] <= pc;
        if (push) begin
            fifo_data[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]   <= aq_pc[aq_rd];
        end
    end

    // The strobe stays combinational so a same-cycle redirect can suppress it.
    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign instr_valid = fifo_count != '0;
    assign instr       = instr_valid ? fifo_data[fifo_rd] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[fifo_rd] : '0;
    assign busy        = (state != IDLE) || (outstanding != '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> outstanding != '0);
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset)
        outstanding <= DEPTH_CNT);
    a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
        drop_cnt <= outstanding);
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (push && !pop) |-> fifo_count < DEPTH_CNT);

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller: a queue-based memory and
// sequential-PC reference model predict every request and delivered instruction.
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;

    fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_rsp_t;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       lat_min = 1;
    int       lat_max = 1;
    int       last_due = 0;
    bit       rsp_stale = 1'b0;
    bit       fe = 1'b1;

    exp_t     exp_q[$];
    mem_rsp_t memq[$];

    mstate_t     m_state = M_IDLE;
    logic [31:0] m_pc = RESET_PC;
    int          in_flight = 0;
    int          buffered = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    // One clock of stimulus; the memory model answers any response due in this cycle.
    task automatic drive_cycle(input bit f, input bit rv, input logic [31:0] rpc, input bit rdy);
        mem_rsp_t m;
        @(posedge clk);
        #1;
        fetch_en       = f;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        if (reset && memq.size() != 0 && memq[0].due == cyc) begin
            m           = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(m.addr);
            rsp_stale   = m.stale;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            rsp_stale   = 1'b0;
        end
    endtask

    // Reference model: sequential PC stream, credit-limited requests, flush on redirect.
    initial begin : model
        bit credit;
        bit exp_req;
        bit popped;
        int due;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_state   = M_IDLE;
                m_pc      = RESET_PC;
                in_flight = 0;
                buffered  = 0;
                last_due  = 0;
                memq.delete();
                exp_q.delete();
            end else begin
                credit  = (in_flight + buffered) < DEPTH;
                exp_req = (m_state == M_RUN) && credit && !redirect_valid;
                popped  = (buffered != 0) && instr_ready && !redirect_valid;
                check("instr_valid", {31'd0, instr_valid}, {31'd0, buffered != 0});
                check("busy", {31'd0, busy}, {31'd0, (m_state != M_IDLE) || (in_flight != 0)});
                check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
                if (exp_req && imem_req) check("imem_addr", imem_addr, m_pc);

                in_flight = in_flight + int'(exp_req) - int'(imem_rvalid);
                if (redirect_valid) begin
                    buffered = 0;
                    m_pc     = {redirect_pc[31:2], 2'b00};
                    exp_q.delete();
                    foreach (memq[i]) memq[i].stale = 1'b1;
                end else begin
                    if (exp_req) begin
                        exp_q.push_back({m_pc, mem_word(m_pc)});
                        due = cyc + int'($urandom_range(lat_min, lat_max));
                        if (due <= last_due) due = last_due + 1;
                        last_due = due;
                        memq.push_back('{addr: m_pc, due: due, stale: 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                    if (imem_rvalid && !rsp_stale) buffered++;
                    if (popped) buffered--;
                end

                case (m_state)
                    M_IDLE:  if (fetch_en) m_state = M_RUN;
                    M_RUN:   if (!fetch_en) m_state = M_DRAIN;
                    default: begin
                        if (fetch_en)            m_state = M_RUN;
                        else if (in_flight == 0) m_state = M_IDLE;
                    end
                endcase
            end
        end
    end

    // Monitor: every accepted instruction is compared against the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h with nothing expected (cycle %0d)",
                             instr_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr", instr, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'd0;
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (3) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        reset = 1'b1;

        // Streaming at latency 1 with decode always ready.
        repeat (12) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Decode stalls: requests must stop at the credit limit.
        repeat (6) drive_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (8) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect with responses in flight at latency 3.
        lat_min = 3;
        lat_max = 3;
        repeat (4) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        drive_cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        repeat (10) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Drop fetch_en with requests outstanding, then resume.
        repeat (10) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (4) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect coinciding with a response and a pop at latency 1.
        lat_min = 1;
        lat_max = 1;
        repeat (6) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        drive_cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1);
        drive_cycle(1'b1, 1'b1, 32'h0000_3008, 1'b1);
        repeat (6) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        lat_min = 1;
        lat_max = 3;
        fe      = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) fe = !fe;
            drive_cycle(fe, $urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 9) < 7);
        end

        // PC wrap at the top of the address space.
        lat_min = 1;
        lat_max = 1;
        drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (8) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);

        // Asynchronous reset in the middle of the stream.
        #2;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        #1 check_reset_outputs();
        repeat (2) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        reset = 1'b1;
        repeat (20) drive_cycle(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (10) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
